// File: rtl/instr_align_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the instruction align buffer.
// The master modport is the fetch/decode environment; slave is the buffer itself.
interface instr_align_buffer_if #(
    parameter int XLEN = 32
);
    logic            FetchValidF;
    logic            FetchReadyF;
    logic [31:0]     FetchWordF;
    logic            FlushD;
    logic [XLEN-1:0] RedirectPCF;
    logic            InstrValidD;
    logic            InstrReadyD;
    logic [31:0]     InstrRawD;
    logic            CompressedD;
    logic [XLEN-1:0] PCD;

    modport master (
        output FetchValidF, FetchWordF, FlushD, RedirectPCF, InstrReadyD,
        input  FetchReadyF, InstrValidD, InstrRawD, CompressedD, PCD
    );

    modport slave (
        input  FetchValidF, FetchWordF, FlushD, RedirectPCF, InstrReadyD,
        output FetchReadyF, InstrValidD, InstrRawD, CompressedD, PCD
    );
endinterface

// File: rtl/instr_align_buffer.sv
// Halfword realignment queue: slices word-aligned fetch data into 16/32-bit
// instructions presented at bit 0 with their PC, one per cycle.
module instr_align_buffer #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    instr_align_buffer_if.slave      bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] CNT_READY_MAX = PW'(DEPTH - 2);

    logic [15:0]     hw_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            skip_q, skip_d;

    logic [IW-1:0]   rd0, rd1, wr0, wr1;
    logic [15:0]     h0, h1;
    logic            is_cmp, is_full, push, pop;
    logic [PW-1:0]   n_push, n_pop;

    assign rd0 = head_q[IW-1:0];
    assign rd1 = rd0 + 1'b1;
    // Write slot is taken from the pre-pop head so a same-cycle pop cannot shift it.
    assign wr0 = rd0 + count_q[IW-1:0];
    assign wr1 = wr0 + 1'b1;

    assign h0 = hw_q[rd0];
    assign h1 = hw_q[rd1];

    assign is_cmp  = (count_q != '0) && (h0[1:0] != 2'b11);
    assign is_full = (count_q >= PW'(2)) && (h0[1:0] == 2'b11);

    assign bus.FetchReadyF = (count_q <= CNT_READY_MAX);
    assign bus.InstrValidD = is_cmp || is_full;
    assign bus.InstrRawD   = is_full ? {h1, h0} : (is_cmp ? {16'h0000, h0} : 32'h0);
    assign bus.CompressedD = is_cmp;
    assign bus.PCD         = pc_q;

    assign push = bus.FetchValidF && bus.FetchReadyF && !bus.FlushD;
    assign pop  = bus.InstrValidD && bus.InstrReadyD && !bus.FlushD;

    assign n_push = push ? (skip_q ? PW'(1) : PW'(2)) : '0;
    assign n_pop  = pop  ? (is_full ? PW'(2) : PW'(1)) : '0;

    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        pc_d    = pc_q;
        skip_d  = skip_q;
        if (bus.FlushD) begin
            head_d  = '0;
            count_d = '0;
            pc_d    = bus.RedirectPCF & ~XLEN'(1);
            skip_d  = bus.RedirectPCF[1];
        end else begin
            count_d = count_q + n_push - n_pop;
            head_d  = head_q + n_pop;
            if (pop) begin
                pc_d = pc_q + (is_full ? XLEN'(4) : XLEN'(2));
            end
            if (push) begin
                skip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            count_q <= '0;
            pc_q    <= RESET_VECTOR;
            skip_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            skip_q  <= skip_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            if (skip_q) begin
                hw_q[wr0] <= bus.FetchWordF[31:16];
            end else begin
                hw_q[wr0] <= bus.FetchWordF[15:0];
                hw_q[wr1] <= bus.FetchWordF[31:16];
            end
        end
    end
endmodule

// File: tb/tb_instr_align_buffer.sv
// Directed bench for instr_align_buffer (XLEN=32, DEPTH=4, RESET_VECTOR=0).
module tb_instr_align_buffer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    instr_align_buffer_if #(.XLEN(32)) bus ();

    instr_align_buffer #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] w);
        chk({tag, "_rdy"}, 64'(bus.FetchReadyF), 64'd1);
        bus.FetchValidF = 1'b1;
        bus.FetchWordF  = w;
        @(negedge clk);
        bus.FetchValidF = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [31:0] raw, input logic [31:0] pc,
                       input logic cmp);
        chk({tag, "_vld"}, 64'(bus.InstrValidD), 64'd1);
        chk({tag, "_raw"}, 64'(bus.InstrRawD), 64'(raw));
        chk({tag, "_pc"},  64'(bus.PCD), 64'(pc));
        chk({tag, "_cmp"}, 64'(bus.CompressedD), 64'(cmp));
        bus.InstrReadyD = 1'b1;
        @(negedge clk);
        bus.InstrReadyD = 1'b0;
    endtask

    task automatic flush(input string tag, input logic [31:0] pc, input logic [31:0] w);
        bus.FlushD      = 1'b1;
        bus.RedirectPCF = pc;
        bus.FetchValidF = 1'b1;
        bus.FetchWordF  = w;
        bus.InstrReadyD = 1'b1;
        @(negedge clk);
        bus.FlushD      = 1'b0;
        bus.FetchValidF = 1'b0;
        bus.InstrReadyD = 1'b0;
        chk({tag, "_vld"}, 64'(bus.InstrValidD), 64'd0);
        chk({tag, "_pc"},  64'(bus.PCD), 64'(pc & 32'hFFFF_FFFE));
    endtask

    initial begin
        bus.FetchValidF = 1'b0;
        bus.FetchWordF  = '0;
        bus.FlushD      = 1'b0;
        bus.RedirectPCF = '0;
        bus.InstrReadyD = 1'b0;

        #12;
        chk("rst_vld", 64'(bus.InstrValidD), 64'd0);
        chk("rst_rdy", 64'(bus.FetchReadyF), 64'd1);
        chk("rst_raw", 64'(bus.InstrRawD), 64'd0);
        chk("rst_cmp", 64'(bus.CompressedD), 64'd0);
        chk("rst_pc",  64'(bus.PCD), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // two 32-bit instructions
        push("t1a", 32'h0000_0013);
        pop("t1a", 32'h0000_0013, 32'h0, 1'b0);
        push("t1b", 32'h0010_0093);
        pop("t1b", 32'h0010_0093, 32'h4, 1'b0);
        chk("t1_empty", 64'(bus.InstrValidD), 64'd0);

        // two compressed halfwords in one word
        flush("t2f", 32'h0, 32'h0);
        push("t2", 32'h4505_0505);
        pop("t2a", 32'h0000_0505, 32'h0, 1'b1);
        pop("t2b", 32'h0000_4505, 32'h2, 1'b1);

        // 32-bit instruction straddling two fetch words
        flush("t3f", 32'h0, 32'h0);
        push("t3a", 32'h0093_4505);
        pop("t3a", 32'h0000_4505, 32'h0, 1'b1);
        chk("t3_half_vld", 64'(bus.InstrValidD), 64'd0);
        chk("t3_half_cmp", 64'(bus.CompressedD), 64'd0);
        chk("t3_half_raw", 64'(bus.InstrRawD), 64'd0);
        push("t3b", 32'h0000_0010);
        pop("t3b", 32'h0010_0093, 32'h2, 1'b0);
        pop("t3c", 32'h0000_0000, 32'h6, 1'b1);

        // redirect to odd halfword; flush-cycle word must vanish
        flush("t4f", 32'h102, 32'hDEAD_BEEF);
        chk("t4f_rdy", 64'(bus.FetchReadyF), 64'd1);
        push("t4", 32'h0505_ABCD);
        pop("t4", 32'h0000_0505, 32'h102, 1'b1);
        chk("t4_empty", 64'(bus.InstrValidD), 64'd0);

        // backpressure, head starts at slot 1 so the 32-bit op wraps 3->0
        push("t5a", 32'h4505_0505);
        push("t5b", 32'h0010_0093);
        chk("t5_full_rdy", 64'(bus.FetchReadyF), 64'd0);
        bus.FetchValidF = 1'b1;
        bus.FetchWordF  = 32'h0000_0013;
        repeat (3) @(negedge clk);
        bus.FetchValidF = 1'b0;
        chk("t5_stall_rdy", 64'(bus.FetchReadyF), 64'd0);
        pop("t5a", 32'h0000_0505, 32'h104, 1'b1);
        chk("t5_cnt3_rdy", 64'(bus.FetchReadyF), 64'd0);
        pop("t5b", 32'h0000_4505, 32'h106, 1'b1);
        chk("t5_cnt2_rdy", 64'(bus.FetchReadyF), 64'd1);
        pop("t5c", 32'h0010_0093, 32'h108, 1'b0);
        chk("t5_empty", 64'(bus.InstrValidD), 64'd0);
        push("t5d", 32'h0000_0013);
        pop("t5d", 32'h0000_0013, 32'h10C, 1'b0);

        // asynchronous reset with three halfwords held
        flush("t6f", 32'h2, 32'h1111_1111);
        push("t6a", 32'h0505_FFFF);
        push("t6b", 32'h0000_0013);
        chk("t6_pre_vld", 64'(bus.InstrValidD), 64'd1);
        chk("t6_pre_raw", 64'(bus.InstrRawD), 64'h505);
        chk("t6_pre_pc",  64'(bus.PCD), 64'h2);
        chk("t6_pre_rdy", 64'(bus.FetchReadyF), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_vld", 64'(bus.InstrValidD), 64'd0);
        chk("t6_rdy", 64'(bus.FetchReadyF), 64'd1);
        chk("t6_raw", 64'(bus.InstrRawD), 64'd0);
        chk("t6_cmp", 64'(bus.CompressedD), 64'd0);
        chk("t6_pc",  64'(bus.PCD), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_post_vld", 64'(bus.InstrValidD), 64'd0);
        chk("t6_post_pc",  64'(bus.PCD), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_align_buffer.md
Name: instr_align_buffer

Overview:
- Halfword-granular realignment queue between the fetch interface and the decompressor.
- Accepts 32-bit, word-aligned fetch words and slices them into instructions that are 16-bit (op != 2'b11) or 32-bit.
- 32-bit instructions may straddle fetch words.
- Presents one instruction per cycle, aligned to bit 0, with its PC, as the raw-instruction input of the decode-stage decompressor.

Parameters:
- XLEN, 32, PC width (32 or 64).
- DEPTH, 4, queue capacity in halfwords; power of two, minimum 4.
- RESET_VECTOR, 0, PC of the first instruction after reset.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- FetchValidF  input  1  FetchWordF valid.
- FetchReadyF  output  1  buffer can accept a fetch word this cycle.
- FetchWordF  input  32  word-aligned fetch data; halfword 0 is bits [15:0].
- FlushD  input  1  discard all buffered halfwords and redirect.
- RedirectPCF  input  XLEN  new PC on FlushD; bit 0 is ignored.
- InstrValidD  output  1  InstrRawD/PCD hold a complete instruction.
- InstrReadyD  input  1  decode consumes the instruction this cycle.
- InstrRawD  output  32  aligned instruction; upper 16 bits are zero when compressed.
- CompressedD  output  1  InstrRawD[1:0] != 2'b11.
- PCD  output  XLEN  PC of InstrRawD.

Behaviour:
- State:
  - circular halfword array hw[DEPTH];
  - head pointer and count, each log2(DEPTH)+1 bits (count range 0..DEPTH);
  - PC register pcq;
  - skip flag.
- Reset (asynchronous, reset_n low): count=0, head=0, pcq=RESET_VECTOR, skip=0. Outputs: InstrValidD=0, FetchReadyF=1, InstrRawD=0, CompressedD=0, PCD=RESET_VECTOR. Reset asserted mid-transfer discards all contents immediately.
- FetchReadyF = (count <= DEPTH-2). It depends on registered count only, with no combinational path from InstrReadyD.
- Enqueue when FetchValidF && FetchReadyF:
  - skip=0: push FetchWordF[15:0] then [31:16] (count += 2).
  - skip=1: push only [31:16] (count += 1), then clear skip.
- Output decode, combinational from the head of the queue:
  - h0 = hw[head], h1 = hw[head+1] (indices mod DEPTH).
  - Compressed: count>=1 and h0[1:0] != 2'b11.
  - Full instruction: count>=2 and h0[1:0] == 2'b11.
  - InstrValidD = compressed || full.
  - InstrRawD = {16'b0, h0} when compressed, {h1, h0} when full, 0 when invalid.
  - PCD = pcq; CompressedD follows h0 when count>=1, else 0.
- Dequeue when InstrValidD && InstrReadyD:
  - head += 1 (compressed) or 2 (full); count decreases by the same amount.
  - pcq += 2 or 4, wrapping modulo 2^XLEN.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + pushed - popped. The write index is head+count, computed before the pop.
- Half-instruction (count==1, h0[1:0]==2'b11): InstrValidD=0 until the next word arrives. Zero-bubble case: output is valid in the cycle after the enqueue.
- Latency: a word accepted in cycle N can produce InstrValidD in cycle N+1 at the earliest. No same-cycle bypass.
- FlushD (synchronous, highest priority): count=0, head=0, pcq={RedirectPCF[XLEN-1:1],1'b0}, skip=RedirectPCF[1]. Any enqueue or dequeue in the same cycle is ignored. The fetch word presented in the flush cycle is dropped even if FetchReadyF=1. InstrValidD=0 in the cycle following the flush.
- Pointer wrap: head and write index wrap modulo DEPTH. A 32-bit instruction split across hw[DEPTH-1] and hw[0] is assembled correctly.
- Full/empty:
  - count==DEPTH → FetchReadyF=0; decode may still drain.
  - count==0 → InstrValidD=0.
- This block does no instruction legality check; it passes bits through unchanged.

Test Plan:
1. Reset with reset_n low, then release; push 0x00000013 then 0x00100093 → two 32-bit instructions in order, PCD=0x0 then 0x4, CompressedD=0, FetchReadyF=1 throughout.
2. Push 0x4505_0505 (two compressed halfwords) → InstrRawD=0x00000505 at PC 0x0, then 0x00004505 at PC 0x2, CompressedD=1 for both.
3. Straddle: push 0x0093_4505, then 0x0000_0010 → 0x4505 compressed at PC 0x0; 0x00100093 at PC 0x2 becomes valid only after the second word is accepted.
4. FlushD with RedirectPCF=0x102, then push 0x0505_ABCD → 0xABCD discarded; InstrRawD=0x00000505 at PCD=0x102. The word presented in the flush cycle is never emitted.
5. Backpressure: hold InstrReadyD=0 and stream words → FetchReadyF drops at count 3 (DEPTH=4); no data is lost. Release → instructions emitted in order with correct PCs across pointer wrap.
6. Assert reset_n low asynchronously while count=3 and InstrValidD=1 → outputs drop to their reset values before the next clk edge; PCD=RESET_VECTOR.
